// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Purpose  : Control/next-PC bundle between the decode stage and pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int Width = 8
);
    logic [Width-1:0] PC;
    logic             Stall;
    logic             Branch;
    logic             BranchTaken;
    logic [Width-1:0] BranchOffset;
    logic             Jump;
    logic [Width-1:0] JumpTarget;
    logic             Call;
    logic             Ret;
    logic [Width-1:0] PCin;
    logic             RasEmpty;
    logic             RasFull;
    logic             RasError;

    modport master (
        output PC, Stall, Branch, BranchTaken, BranchOffset,
               Jump, JumpTarget, Call, Ret,
        input  PCin, RasEmpty, RasFull, RasError
    );

    modport slave (
        input  PC, Stall, Branch, BranchTaken, BranchOffset,
               Jump, JumpTarget, Call, Ret,
        output PCin, RasEmpty, RasFull, RasError
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Next-PC selection with a return-address stack. Define
//            PC_SEQ_RAS_WRAP_EN to let a full stack overwrite its oldest entry.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int Width    = 8,
    parameter int RasDepth = 4
) (
    input  wire logic      CLK,
    input  wire logic      Reset,
    pc_sequencer_if.slave  bus
);
    localparam int c_PTR_W = $clog2(RasDepth);
    localparam int c_CNT_W = c_PTR_W + 1;
`ifdef PC_SEQ_RAS_WRAP_EN
    localparam bit c_WRAP_EN = 1'b1;
`else
    localparam bit c_WRAP_EN = 1'b0;
`endif

    logic [Width-1:0]   r_ras [RasDepth];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_error;

    logic [Width-1:0]   w_pc_inc;
    logic [Width-1:0]   w_pc_branch;
    logic [Width-1:0]   w_top;
    logic               w_empty;
    logic               w_full;
    logic               w_active;
    logic               w_ret;
    logic               w_call;
    logic               w_pop;
    logic               w_push;
    logic               w_underflow;
    logic               w_overflow;

    assign w_pc_inc    = bus.PC + Width'(1);
    assign w_pc_branch = bus.PC + bus.BranchOffset;
    // r_ptr addresses the next free slot, so the top sits one below it.
    assign w_top       = r_ras[r_ptr - c_PTR_W'(1)];
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_CNT_W'(RasDepth));

    assign w_active    = !Reset && !bus.Stall;
    assign w_ret       = w_active && bus.Ret;
    assign w_call      = w_active && bus.Call && !bus.Ret;
    assign w_pop       = w_ret && !w_empty;
    assign w_underflow = w_ret && w_empty;
    assign w_push      = w_call && (!w_full || c_WRAP_EN);
    assign w_overflow  = w_call && w_full && !c_WRAP_EN;

    always_comb begin
        bus.PCin = w_pc_inc;
        if (Reset) begin
            bus.PCin = '0;
        end else if (bus.Stall) begin
            bus.PCin = bus.PC;
        end else if (bus.Ret) begin
            bus.PCin = w_empty ? w_pc_inc : w_top;
        end else if (bus.Call || bus.Jump) begin
            bus.PCin = bus.JumpTarget;
        end else if (bus.Branch && bus.BranchTaken) begin
            bus.PCin = w_pc_branch;
        end
    end

    // Forced values during reset keep the flags consistent before the clearing edge.
    assign bus.RasEmpty = Reset || w_empty;
    assign bus.RasFull  = !Reset && w_full;
    assign bus.RasError = !Reset && r_error;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_ras[r_ptr] <= w_pc_inc;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_pop) begin
                r_ptr   <= r_ptr - c_PTR_W'(1);
                r_count <= r_count - c_CNT_W'(1);
            end else if (w_push) begin
                // When full with wrap enabled, r_ptr already points at the oldest entry.
                r_ptr <= r_ptr + c_PTR_W'(1);
                if (!w_full) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end
            if (w_underflow || w_overflow) begin
                r_error <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed and random checks of pc_sequencer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 4;
`ifdef PC_SEQ_RAS_WRAP_EN
    localparam bit c_WRAP = 1'b1;
`else
    localparam bit c_WRAP = 1'b0;
`endif

    logic CLK;
    logic Reset;
    int   n_checks;
    int   n_fail;

    int   m_stack [$];
    bit   m_error;

    pc_sequencer_if #(.Width(c_WIDTH)) bus ();

    pc_sequencer #(
        .Width    (c_WIDTH),
        .RasDepth (c_DEPTH)
    ) u_dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input logic [7:0] pc);
        Reset            = 1'b0;
        bus.PC           = pc;
        bus.Stall        = 1'b0;
        bus.Branch       = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchOffset = 8'h00;
        bus.Jump         = 1'b0;
        bus.JumpTarget   = 8'h00;
        bus.Call         = 1'b0;
        bus.Ret          = 1'b0;
    endtask

    // Compares outputs against the model, clocks once, then applies the same step to the model.
    task automatic tick(input string tag);
        logic [7:0] exp_pc;
        #1;
        if (Reset)                              exp_pc = 8'h00;
        else if (bus.Stall)                     exp_pc = bus.PC;
        else if (bus.Ret && m_stack.size() > 0) exp_pc = 8'(m_stack[$]);
        else if (bus.Ret)                       exp_pc = bus.PC + 8'd1;
        else if (bus.Call || bus.Jump)          exp_pc = bus.JumpTarget;
        else if (bus.Branch && bus.BranchTaken) exp_pc = bus.PC + bus.BranchOffset;
        else                                    exp_pc = bus.PC + 8'd1;
        check({tag, ".pcin"}, 32'(bus.PCin), 32'(exp_pc));
        check({tag, ".empty"}, 32'(bus.RasEmpty), 32'(Reset || m_stack.size() == 0));
        check({tag, ".full"}, 32'(bus.RasFull), 32'(!Reset && m_stack.size() == c_DEPTH));
        check({tag, ".err"}, 32'(bus.RasError), 32'(!Reset && m_error));
        @(posedge CLK);
        if (Reset) begin
            m_stack.delete();
            m_error = 1'b0;
        end else if (!bus.Stall) begin
            if (bus.Ret) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
                else                    m_error = 1'b1;
            end else if (bus.Call) begin
                if (m_stack.size() < c_DEPTH) begin
                    m_stack.push_back(int'(bus.PC) + 1);
                end else if (c_WRAP) begin
                    void'(m_stack.pop_front());
                    m_stack.push_back(int'(bus.PC) + 1);
                end else begin
                    m_error = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle(8'h00);
        Reset = 1'b1;
        tick("reset");
        Reset = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_ret [4];
        n_checks = 0;
        n_fail   = 0;
        m_error  = 1'b0;
        idle(8'h00);
        @(posedge CLK);
        #1;
        do_reset();

        idle(8'h05); #1 check("seq", 32'(bus.PCin), 32'h06); tick("seq");
        idle(8'hFF); #1 check("seq_wrap", 32'(bus.PCin), 32'h00); tick("seq_wrap");

        idle(8'h10); bus.Branch = 1'b1; bus.BranchTaken = 1'b1; bus.BranchOffset = 8'hFC;
        #1 check("br_taken", 32'(bus.PCin), 32'h0C); tick("br_taken");
        bus.BranchTaken = 1'b0;
        #1 check("br_not", 32'(bus.PCin), 32'h11); tick("br_not");

        idle(8'h20); bus.Call = 1'b1; bus.JumpTarget = 8'h80;
        #1 check("call", 32'(bus.PCin), 32'h80); tick("call");
        idle(8'h85); bus.Ret = 1'b1;
        #1 check("ret", 32'(bus.PCin), 32'h21); tick("ret");
        check("ret_empty", 32'(bus.RasEmpty), 32'h1);

        idle(8'h30); bus.Ret = 1'b1;
        #1 check("underflow_pc", 32'(bus.PCin), 32'h31); tick("underflow");
        check("underflow_err", 32'(bus.RasError), 32'h1);
        idle(8'h31); tick("sticky1");
        idle(8'h32); tick("sticky2");
        check("err_sticky", 32'(bus.RasError), 32'h1);
        do_reset();
        check("err_cleared", 32'(bus.RasError), 32'h0);

        for (int i = 1; i <= 5; i++) begin
            idle(8'(i)); bus.Call = 1'b1; bus.JumpTarget = 8'(i + 1);
            tick("call5");
        end
        if (c_WRAP) exp_ret = '{8'h06, 8'h05, 8'h04, 8'h03};
        else        exp_ret = '{8'h05, 8'h04, 8'h03, 8'h02};
        for (int i = 0; i < 4; i++) begin
            idle(8'h90); bus.Ret = 1'b1;
            #1 check("ret4", 32'(bus.PCin), 32'(exp_ret[i]));
            tick("ret4");
        end
        check("ret4_err", 32'(bus.RasError), 32'(!c_WRAP));
        do_reset();

        idle(8'h10); bus.Call = 1'b1; bus.JumpTarget = 8'h50; tick("hold_a");
        idle(8'h50); bus.Call = 1'b1; bus.JumpTarget = 8'h60; tick("hold_b");
        idle(8'h40); bus.Stall = 1'b1; bus.Call = 1'b1; bus.Jump = 1'b1; bus.Ret = 1'b1;
        bus.JumpTarget = 8'h99;
        #1 check("stall_pc", 32'(bus.PCin), 32'h40); tick("stall");
        check("stall_cnt", 32'(m_stack.size()), 32'd2);
        idle(8'h41); Reset = 1'b1; tick("mid_reset");
        idle(8'h00); #1 check("mid_reset_empty", 32'(bus.RasEmpty), 32'h1);
        bus.Ret = 1'b1; tick("post_reset_ret");

        for (int n = 0; n < 400; n++) begin
            idle(8'($urandom));
            Reset            = ($urandom_range(0, 49) == 0);
            bus.Stall        = ($urandom_range(0, 5) == 0);
            bus.Ret          = ($urandom_range(0, 3) == 0);
            bus.Call         = ($urandom_range(0, 2) == 0);
            bus.Jump         = ($urandom_range(0, 4) == 0);
            bus.Branch       = 1'($urandom);
            bus.BranchTaken  = 1'($urandom);
            bus.BranchOffset = 8'($urandom);
            bus.JumpTarget   = 8'($urandom);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
